load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time between the CPU and a single-port data memory.
// Handles byte/half/word loads and stores (SB/SH as read-modify-write) plus the LWL/LWR merges.
module load_store_unit #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] rt_old,
   output logic        resp_valid,
   output logic [31:0] load_data,
   output logic        addr_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_WriteData,
   output logic        mem_MemWrite,
   output logic        mem_MemRead,
   input  logic [31:0] mem_ReadData
);
   // state | meaning
   // IDLE  | ready, waiting for req_valid
   // READ  | memory read strobe, word captured at end of cycle
   // WRITE | single-cycle write strobe (SW, or merged SB/SH word)
   // RESP  | one-cycle completion pulse with load result
   // ERR   | one-cycle completion pulse with addr_error, no memory traffic
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [3:0] OP_LB  = 4'h0;
   localparam logic [3:0] OP_LBU = 4'h1;
   localparam logic [3:0] OP_LH  = 4'h2;
   localparam logic [3:0] OP_LHU = 4'h3;
   localparam logic [3:0] OP_LW  = 4'h4;
   localparam logic [3:0] OP_LWL = 4'h5;
   localparam logic [3:0] OP_LWR = 4'h6;
   localparam logic [3:0] OP_SB  = 4'h8;
   localparam logic [3:0] OP_SH  = 4'h9;
   localparam logic [3:0] OP_SW  = 4'hA;

   logic [2:0]  state_q, state_d;
   logic [3:0]  op_q;
   logic [31:0] addr_q, sdata_q, rt_q, word_q;
   logic [1:0]  k, kk, bl;
   logic        hl;
   logic [4:0]  sh_l, sh_r;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] fmt, merged, keep;

   function automatic logic bad_access(input logic [3:0] o, input logic [1:0] a);
      case (o)
         OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: bad_access = 1'b0;
         OP_LH, OP_LHU, OP_SH:                 bad_access = a[0];
         OP_LW, OP_SW:                         bad_access = (a != 2'b00);
         default:                              bad_access = 1'b1;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid) begin
            if (bad_access(op, addr[1:0])) state_d = S_ERR;
            else if (op == OP_SW)          state_d = S_WRITE;
            else                           state_d = S_READ;
         end
         S_READ:  state_d = (op_q == OP_SB || op_q == OP_SH) ? S_WRITE : S_RESP;
         S_WRITE: state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         addr_q  <= 32'd0;
         sdata_q <= 32'd0;
         rt_q    <= 32'd0;
         word_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req_valid) begin
            op_q    <= op;
            addr_q  <= addr;
            sdata_q <= store_data;
            rt_q    <= rt_old;
         end
         if (state_q == S_READ) word_q <= mem_ReadData;
      end
   end

   // kk is the byte offset as seen in big-endian terms; bl/hl are physical lane indices from bit 0.
   assign k        = addr_q[1:0];
   assign kk       = BIG_ENDIAN ? k : ~k;
   assign bl       = BIG_ENDIAN ? ~k : k;
   assign hl       = BIG_ENDIAN ? ~k[1] : k[1];
   assign sh_l     = {kk, 3'b000};
   assign sh_r     = {~kk, 3'b000};
   assign byte_sel = word_q[{bl, 3'b000} +: 8];
   assign half_sel = word_q[{hl, 4'b0000} +: 16];
   assign keep     = 32'hFFFF_FFFF >> sh_r;

   always_comb begin
      fmt = 32'd0;
      case (op_q)
         OP_LB:   fmt = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  fmt = {24'd0, byte_sel};
         OP_LH:   fmt = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  fmt = {16'd0, half_sel};
         OP_LW:   fmt = word_q;
         OP_LWL:  fmt = (word_q << sh_l) | (rt_q & ~(32'hFFFF_FFFF << sh_l));
         OP_LWR:  fmt = ((word_q >> sh_r) & keep) | (rt_q & ~keep);
         default: fmt = 32'd0;
      endcase
   end

   always_comb begin
      merged = word_q;
      if (op_q == OP_SB)      merged[{bl, 3'b000} +: 8]   = sdata_q[7:0];
      else if (op_q == OP_SH) merged[{hl, 4'b0000} +: 16] = sdata_q[15:0];
   end

   assign req_ready     = (state_q == S_IDLE);
   assign resp_valid    = (state_q == S_RESP) || (state_q == S_ERR);
   assign addr_error    = (state_q == S_ERR);
   assign load_data     = (state_q == S_RESP && !op_q[3]) ? fmt : 32'd0;
   assign mem_MemRead   = (state_q == S_READ);
   assign mem_MemWrite  = (state_q == S_WRITE);
   assign mem_WriteData = (state_q == S_WRITE) ? ((op_q == OP_SW) ? sdata_q : merged) : 32'd0;
   assign mem_address   = (state_q == S_READ || state_q == S_WRITE || state_q == S_RESP)
                          ? {addr_q[31:2], 2'b00} : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model predicting every output cycle,
// memory device model, directed scenarios and randomized traffic.
module tb_load_store_unit;
   localparam bit BE = 1'b1;
   localparam logic [3:0] LB = 4'h0, LBU = 4'h1, LH = 4'h2, LHU = 4'h3, LW = 4'h4;
   localparam logic [3:0] LWL = 4'h5, LWR = 4'h6, SB = 4'h8, SH = 4'h9, SW = 4'hA;

   logic        clock, reset_n, req_valid, req_ready, resp_valid, addr_error;
   logic [3:0]  op;
   logic [31:0] addr, store_data, rt_old, load_data;
   logic [31:0] mem_address, mem_WriteData, mem_ReadData;
   logic        mem_MemWrite, mem_MemRead;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.BIG_ENDIAN(BE)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .addr(addr), .store_data(store_data), .rt_old(rt_old),
      .resp_valid(resp_valid), .load_data(load_data), .addr_error(addr_error),
      .mem_address(mem_address), .mem_WriteData(mem_WriteData), .mem_MemWrite(mem_MemWrite),
      .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- memory device ----------------
   logic [31:0] dev_mem [128];
   logic [31:0] ref_mem [128];
   int rd_cnt = 0, wr_cnt = 0;
   logic [31:0] last_wdata = 32'd0;

   always @(negedge clock) if (mem_MemRead) mem_ReadData <= dev_mem[mem_address[8:2]];
   always @(posedge clock) begin
      if (mem_MemRead) rd_cnt++;
      if (mem_MemWrite) begin
         wr_cnt++;
         last_wdata = mem_WriteData;
         dev_mem[mem_address[8:2]] = mem_WriteData;
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit          ready, rd, wr, resp, err;
      logic [31:0] addr, wdata, ldata;
   } cyc_t;
   cyc_t exp_q[$];

   function automatic cyc_t blank(input bit rdy);
      cyc_t c;
      c.ready = rdy; c.rd = 0; c.wr = 0; c.resp = 0; c.err = 0;
      c.addr = 0; c.wdata = 0; c.ldata = 0;
      return c;
   endfunction

   // byte at memory offset k (address order) within a word
   function automatic logic [7:0] mbyte(input logic [31:0] w, input int k);
      return 8'((w >> (8 * (BE ? 3 - k : k))) & 32'hFF);
   endfunction

   function automatic logic [31:0] fmt_model(input logic [3:0] o, input int k,
                                             input logic [31:0] w, input logic [31:0] rt);
      logic [15:0] hw;
      int kk, sh;
      kk = BE ? k : 3 - k;
      hw = BE ? {mbyte(w, k), mbyte(w, k + 1)} : {mbyte(w, k + 1), mbyte(w, k)};
      case (o)
         LB:  return 32'($signed(mbyte(w, k)));
         LBU: return {24'd0, mbyte(w, k)};
         LH:  return 32'($signed(hw));
         LHU: return {16'd0, hw};
         LW:  return w;
         LWL: begin sh = 8 * kk; return (w << sh) | (rt & ((32'h1 << sh) - 32'h1)); end
         LWR: begin sh = 8 * (3 - kk); return (w >> sh) | (rt & ~(32'hFFFF_FFFF >> sh)); end
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] merge_model(input logic [3:0] o, input int k,
                                               input logic [31:0] w, input logic [31:0] sd);
      logic [7:0]  b [4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) b[i] = mbyte(w, i);
      if (o == SB) b[k] = sd[7:0];
      else if (BE) begin b[k] = sd[15:8]; b[k + 1] = sd[7:0]; end
      else begin b[k] = sd[7:0]; b[k + 1] = sd[15:8]; end
      r = 0;
      for (int i = 0; i < 4; i++) r = r | (32'(b[i]) << (8 * (BE ? 3 - i : i)));
      return r;
   endfunction

   function automatic void push_txn(input logic [3:0] o, input logic [31:0] a,
                                    input logic [31:0] sd, input logic [31:0] rt);
      cyc_t rd, wr, rs;
      bit legal, mis;
      int k;
      logic [31:0] w;
      k = int'(a[1:0]);
      w = ref_mem[a[8:2]];
      legal = (o <= 4'h6) || (o >= 4'h8 && o <= 4'hA);
      mis = ((o == LH || o == LHU || o == SH) && a[0]) || ((o == LW || o == SW) && a[1:0] != 2'b00);
      rd = blank(0); wr = blank(0); rs = blank(0);
      rd.rd = 1; rd.addr = {a[31:2], 2'b00};
      wr.wr = 1; wr.addr = rd.addr;
      rs.resp = 1; rs.addr = rd.addr;
      if (!legal || mis) begin
         rs.err = 1; rs.addr = 0;
         exp_q.push_back(rs);
      end else if (o == SW) begin
         wr.wdata = sd;
         exp_q.push_back(wr); exp_q.push_back(rs);
      end else if (o == SB || o == SH) begin
         wr.wdata = merge_model(o, k, w, sd);
         exp_q.push_back(rd); exp_q.push_back(wr); exp_q.push_back(rs);
      end else begin
         rs.ldata = fmt_model(o, k, w, rt);
         exp_q.push_back(rd); exp_q.push_back(rs);
      end
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) exp_q.delete();
      else if (exp_q.size() != 0) begin
         cyc_t e;
         e = exp_q.pop_front();
         if (e.wr) ref_mem[e.addr[8:2]] = e.wdata;
      end else if (req_valid) push_txn(op, addr, store_data, rt_old);
   end

   // every cycle: DUT outputs against the model's prediction
   always @(negedge clock) begin
      cyc_t e;
      e = (exp_q.size() != 0) ? exp_q[0] : blank(1);
      check("req_ready", 32'(req_ready), 32'(e.ready));
      check("resp_valid", 32'(resp_valid), 32'(e.resp));
      check("addr_error", 32'(addr_error), 32'(e.err));
      check("load_data", load_data, e.ldata);
      check("mem_address", mem_address, e.addr);
      check("mem_WriteData", mem_WriteData, e.wdata);
      check("mem_MemRead", 32'(mem_MemRead), 32'(e.rd));
      check("mem_MemWrite", 32'(mem_MemWrite), 32'(e.wr));
   end

   // ---------------- stimulus ----------------
   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      dev_mem[a[8:2]] = v;
      ref_mem[a[8:2]] = v;
   endtask

   task automatic do_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rt, output logic [31:0] ld, output logic er,
                         output int lat);
      req_valid = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0; ld = 32'd0; er = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         if (resp_valid) begin lat = i; ld = load_data; er = addr_error; break; end
      end
      @(posedge clock); #1;
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, "_ready"}, 32'(req_ready), 32'd1);
      check({nm, "_outs"}, {resp_valid, addr_error, mem_MemRead, mem_MemWrite}, 32'd0);
      check({nm, "_data"}, load_data | mem_WriteData | mem_address, 32'd0);
   endtask

   initial begin
      logic [31:0] ld;
      logic er;
      int lat, r0, w0;
      logic [3:0] legal_ops [10] = '{LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW};

      reset_n = 1'b0; req_valid = 1'b0; op = 4'd0; addr = 0; store_data = 0; rt_old = 0;
      for (int i = 0; i < 128; i++) begin ref_mem[i] = $urandom; dev_mem[i] = ref_mem[i]; end
      #1;
      check_idle_outputs("reset0");
      #11 reset_n = 1'b1;
      @(posedge clock); #1;

      // pin the model itself with hand-computed values
      check("model_lb", fmt_model(LB, 0, 32'h8822F344, 0), 32'hFFFFFF88);
      check("model_lwr", fmt_model(LWR, 1, 32'h11223344, 32'hAABBCCDD), 32'hAABB1122);
      check("model_sb", merge_model(SB, 2, 32'h11223344, 32'hAA), 32'h1122AA44);

      preload(32'h100, 32'h8822F344);
      do_req(LB, 32'h100, 0, 0, ld, er, lat);
      check("lb_data", ld, 32'hFFFFFF88); check("lb_lat", lat, 2);
      do_req(LBU, 32'h100, 0, 0, ld, er, lat);
      check("lbu_data", ld, 32'h00000088); check("lbu_lat", lat, 2);
      do_req(LH, 32'h102, 0, 0, ld, er, lat);
      check("lh_data", ld, 32'hFFFFF344); check("lh_lat", lat, 2);

      preload(32'h100, 32'h11223344);
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(SB, 32'h102, 32'hAA, 0, ld, er, lat);
      check("sb_lat", lat, 3); check("sb_err", 32'(er), 0);
      check("sb_reads", rd_cnt - r0, 1); check("sb_writes", wr_cnt - w0, 1);
      check("sb_wdata", last_wdata, 32'h1122AA44);

      r0 = rd_cnt; w0 = wr_cnt;
      do_req(LH, 32'h101, 0, 0, ld, er, lat);
      check("lh_mis_lat", lat, 1); check("lh_mis_err", 32'(er), 1);
      do_req(4'b0111, 32'h100, 0, 0, ld, er, lat);
      check("ill_lat", lat, 1); check("ill_err", 32'(er), 1);
      check("err_no_mem", (rd_cnt - r0) + (wr_cnt - w0), 0);

      preload(32'h100, 32'h11223344);
      do_req(LWL, 32'h101, 0, 32'hAABBCCDD, ld, er, lat);
      check("lwl_101", ld, 32'h223344DD);
      do_req(LWR, 32'h101, 0, 32'hAABBCCDD, ld, er, lat);
      check("lwr_101", ld, 32'hAABB1122);
      do_req(LWR, 32'h103, 0, 32'hAABBCCDD, ld, er, lat);
      check("lwr_103", ld, 32'h11223344);

      // reset during READ of an SB
      preload(32'h104, 32'h55667788);
      w0 = wr_cnt;
      req_valid = 1'b1; op = SB; addr = 32'h104; store_data = 32'hAA;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("rst_in_read", 32'(mem_MemRead), 1);
      #2 reset_n = 1'b0;
      #1 check_idle_outputs("rst_async");
      @(posedge clock); #1;
      check_idle_outputs("rst_held");
      #2 reset_n = 1'b1;
      do_req(LW, 32'h104, 0, 0, ld, er, lat);
      check("rst_first_accept_lat", lat, 2);
      check("rst_mem_unchanged", ld, 32'h55667788);
      check("rst_no_write", wr_cnt - w0, 0);
      check("rst_dev_mem", dev_mem[32'h104 >> 2], 32'h55667788);

      // back-to-back with req_valid held
      req_valid = 1'b1; op = SW; addr = 32'h108; store_data = 32'hDEADBEEF;
      @(posedge clock); #1;
      op = LW; store_data = 0;
      @(negedge clock); check("b2b_sw_write", 32'(mem_MemWrite), 1);
      @(negedge clock); check("b2b_sw_resp", 32'(resp_valid), 1);
      @(negedge clock); check("b2b_idle", 32'(req_ready), 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(negedge clock); check("b2b_lw_read", 32'(mem_MemRead), 1);
      check("b2b_lw_addr", mem_address, 32'h108);
      @(negedge clock); check("b2b_lw_resp", 32'(resp_valid), 1);
      check("b2b_lw_data", load_data, 32'hDEADBEEF);
      @(posedge clock); #1;

      // randomized traffic; inputs change every cycle even while busy
      repeat (2000) begin
         logic [31:0] a;
         req_valid = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                          : legal_ops[$urandom_range(0, 9)];
         a = 32'h100 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         addr = a; store_data = $urandom; rt_old = $urandom;
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
      #1;
      check("drain", 32'(exp_q.size()), 0);
      for (int i = 64; i < 128; i++) check("mem_final", dev_mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
